// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the digital clock time-keeping path.
//   mode_t          : RUN / SET_HR / SET_MIN mode encodings (3 is unused)
//   SEC/MIN/HR_MAX  : last legal value of each time field
//   SEC/MIN/HR_W    : bit widths of each time field
package clock_time_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button / display bus of the clock time-keeping controller.
//   btn_mode, btn_up, btn_down : debounced one-cycle button pulses
//   sec, min, hour             : current time fields
//   mode                       : current adjust mode (mode_t encoding)
//   tick                       : one-cycle pulse when a new seconds value appears
// master drives the buttons and watches the time; slave is the controller.
interface clock_time_ctrl_if;
  import clock_time_pkg::*;

  logic             btn_mode;
  logic             btn_up;
  logic             btn_down;
  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic [HR_W-1:0]  hour;
  logic [1:0]       mode;
  logic             tick;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  sec, min, hour, mode, tick
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output sec, min, hour, mode, tick
  );

endinterface

// File: rtl/clock_time_ctrl_wrap_counter.sv
// Modulo-(MAX+1) up/down counter used for each time field.
//   clk, reset : clock and synchronous active-high reset
//   inc, dec   : step up / down with wrap; both together hold the value
//   clr        : synchronous clear to 0
//   count      : current value, 0..MAX
//   carry      : inc while at MAX, i.e. this edge wraps MAX -> 0 upward
module wrap_counter
  import clock_time_pkg::*;
#(
  parameter int W   = SEC_W,
  parameter int MAX = SEC_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] TOP = W'(MAX);

  assign carry = inc & (count == TOP);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= (count == TOP) ? '0 : count + 1'b1;
    end else if (dec && !inc) begin
      count <= (count == '0) ? TOP : count - 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping controller: one-second prescaler, sec/min/hour counter cascade
// and a three-state mode FSM for adjusting hours and minutes.
//   clk, reset : system clock and synchronous active-high reset
//   bus        : slave side of clock_time_ctrl_if (buttons in, time/mode/tick out)
// TICK_DIV is the number of clk cycles per second; PRE_W must hold TICK_DIV-1.
module clock_time_ctrl
  import clock_time_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic               clk,
  input  logic               reset,
  clock_time_ctrl_if.slave   bus
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  mode_t            mode_p0;
  logic [PRE_W-1:0] pre_p0;
  logic             tick_p0;

  logic run, set_hr, set_min;
  logic pre_wrap, adj_ok, leave_set;
  logic sec_inc, sec_carry;
  logic min_inc, min_dec, min_carry;
  logic hr_inc, hr_dec, unused_hr_carry;

  logic [SEC_W-1:0] sec_cnt;
  logic [MIN_W-1:0] min_cnt;
  logic [HR_W-1:0]  hr_cnt;

  // Enable / carry steering. A mode press, or up+down together, suppresses
  // any adjust in that cycle; in RUN the buttons never reach the counters.
  always_comb begin
    run       = (mode_p0 == MODE_RUN);
    set_hr    = (mode_p0 == MODE_SET_HR);
    set_min   = (mode_p0 == MODE_SET_MIN);
    pre_wrap  = (pre_p0 == PRE_LAST);
    adj_ok    = !bus.btn_mode && (bus.btn_up ^ bus.btn_down);
    leave_set = set_min && bus.btn_mode;

    sec_inc = run && pre_wrap;
    min_inc = (run && sec_carry) || (set_min && adj_ok && bus.btn_up);
    min_dec = set_min && adj_ok && bus.btn_down;
    hr_inc  = (run && sec_carry && min_carry) || (set_hr && adj_ok && bus.btn_up);
    hr_dec  = set_hr && adj_ok && bus.btn_down;
  end

  // Stage p0: prescaler, tick and mode registers.
  // Outside RUN the prescaler holds; leaving SET_MIN restarts the second.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_p0 <= MODE_RUN;
      pre_p0  <= '0;
      tick_p0 <= 1'b0;
    end else begin
      tick_p0 <= sec_inc;

      if (run) begin
        pre_p0 <= pre_wrap ? '0 : pre_p0 + 1'b1;
      end else if (leave_set) begin
        pre_p0 <= '0;
      end

      case (mode_p0)
        MODE_RUN:     if (bus.btn_mode) mode_p0 <= MODE_SET_HR;
        MODE_SET_HR:  if (bus.btn_mode) mode_p0 <= MODE_SET_MIN;
        MODE_SET_MIN: if (bus.btn_mode) mode_p0 <= MODE_RUN;
        default:      mode_p0 <= MODE_RUN;
      endcase
    end
  end

  wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .dec   (1'b0),
    .clr   (leave_set),
    .count (sec_cnt),
    .carry (sec_carry)
  );

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .dec   (min_dec),
    .clr   (1'b0),
    .count (min_cnt),
    .carry (min_carry)
  );

  // Day rollover has no consumer; the hour counter wraps 23 -> 0 by itself.
  wrap_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk   (clk),
    .reset (reset),
    .inc   (hr_inc),
    .dec   (hr_dec),
    .clr   (1'b0),
    .count (hr_cnt),
    .carry (unused_hr_carry)
  );

  assign bus.sec  = sec_cnt;
  assign bus.min  = min_cnt;
  assign bus.hour = hr_cnt;
  assign bus.mode = mode_p0;
  assign bus.tick = tick_p0;

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-keeping controller for the digital clock display path. It divides the system clock into a one-second tick and sequences a cascade of mod-60/mod-60/mod-24 counters for seconds, minutes and hours, carrying between them. A three-state mode FSM lets the user adjust hours and minutes from debounced button pulses. Outputs feed the BCD/7-segment display stage directly.

## Interface
- TICK_DIV, 100_000_000: system-clock cycles per second; reduced to 4 in simulation.
- PRE_W, 27: prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- btn_mode  in  1  one-cycle pulse, already debounced; advances the mode.
- btn_up  in  1  one-cycle pulse; increments the selected field.
- btn_down  in  1  one-cycle pulse; decrements the selected field.
- sec  out  6  seconds, 0..59, registered.
- min  out  6  minutes, 0..59, registered.
- hour  out  5  hours, 0..23, registered.
- mode  out  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN; registered. Encoding 3 is unused.
- tick  out  1  one-cycle pulse, high in the cycle the new seconds value appears.

## Operation
- Reset: sec, min, hour, mode, tick and the prescaler all go to 0, one edge after reset is sampled high. Reset mid-operation behaves the same.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1, it wraps to 0, sec increments, and tick is registered high.
- Carry chain, all within the same edge:
  - sec 59→0 increments min.
  - min 59→0, together with sec 59→0, increments hour.
  - 23:59:59 wraps to 00:00:00.
- FSM transitions on btn_mode:
  - RUN→SET_HR: prescaler frozen, tick held 0, sec frozen.
  - SET_HR→SET_MIN.
  - SET_MIN→RUN: sec and prescaler cleared to 0.
- SET_HR:
  - btn_up: hour+1, wrapping 23→0.
  - btn_down: hour-1, wrapping 0→23.
  - No carry into or out of any other field.
- SET_MIN: same rules on min, wrapping at 59/0. Hour is unaffected.
- In RUN, btn_up and btn_down are ignored.
- Simultaneous events:
  - btn_up and btn_down together: both ignored.
  - btn_mode with up or down: the mode transition wins and the adjust is ignored.
  - reset overrides everything.
- Unused mode encoding 3 returns to RUN on the next edge.

## Timing
- All outputs are registered with no combinational input-to-output path.
- Button-to-output latency: 1 cycle. A field or mode change is visible the cycle after the pulse is sampled.
- First tick after reset deassertion or SET_MIN→RUN: exactly TICK_DIV edges later. Ticks then repeat every TICK_DIV cycles.
- tick width: exactly 1 cycle.
- Button pulses longer than one cycle are out of contract; each high cycle counts as an event.

## Structure
- Package clock_time_pkg:
  - mode encodings: MODE_RUN, MODE_SET_HR, MODE_SET_MIN.
  - field limits: SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23.
  - field widths: 6, 6, 5.
- Sub-module wrap_counter #(W, MAX):
  - inputs: clk, reset, inc, dec, clr.
  - output: count[W-1:0].
  - output: carry = inc & (count == MAX).
  - inc and dec together produce no change.
  - Instantiated three times.
- The top level holds the prescaler, mode FSM and enable/carry steering.

## Test plan
- Reset then run (TICK_DIV=4): after reset drops, outputs stay 0 for 3 cycles. On the 4th edge sec = 1 and tick = 1 for one cycle. sec = 2 after 8 edges.
- Wrap via adjust, then run:
  - mode pulse, then btn_down → hour = 23.
  - mode pulse, then btn_down → min = 59.
  - mode pulse → RUN with sec = 0.
  - After 60 ticks → 00:00:00 with mode = 0.
- Freeze in SET_HR: set sec = 5, then mode pulse. Wait 40 cycles: sec stays 5 and tick stays 0. Exit to RUN → sec = 0.
- Adjust wrap without carry: in SET_MIN with min = 59 and hour = 3, btn_up → min = 0 and hour stays 3.
- Simultaneous inputs:
  - up+down in SET_HR → hour unchanged.
  - mode+up in SET_HR → mode = 2 and hour unchanged.
- Reset mid-run: assert reset with the prescaler at 2 and time 12:34:56. Next cycle all outputs = 0. sec = 1 exactly 4 edges after deassert.
